// File: rtl/ntt_seq_pkg.sv
// Shared definitions for the NTT1024 command sequencer: host command codes,
// core opcodes, FSM states and command decode helpers.
package ntt_seq_pkg;

    localparam logic [3:0] CMD_CFG   = 4'd0;
    localparam logic [3:0] CMD_LDPRM = 4'd1;
    localparam logic [3:0] CMD_LDW   = 4'd2;
    localparam logic [3:0] CMD_LDDAT = 4'd3;
    localparam logic [3:0] CMD_NTT   = 4'd4;
    localparam logic [3:0] CMD_PWM   = 4'd5;
    localparam logic [3:0] CMD_XFER  = 4'd6;
    localparam logic [3:0] CMD_INTT  = 4'd7;
    localparam logic [3:0] CMD_READ  = 4'd8;

    localparam logic [4:0] OPC_LDPRM = 5'b00001;
    localparam logic [4:0] OPC_LDW   = 5'b00010;
    localparam logic [4:0] OPC_LDDAT = 5'b00011;
    localparam logic [4:0] OPC_NTT   = 5'b00100;
    localparam logic [4:0] OPC_PWM   = 5'b01010;
    localparam logic [4:0] OPC_INTT  = 5'b00111;
    localparam logic [4:0] OPC_XFER  = 5'b01011;
    localparam logic [4:0] OPC_READ  = 5'b01000;

    // 13 bits so that 2*ring_size (2048) fits
    localparam int CNT_W = 13;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_STREAM, S_WAIT, S_WINDOW, S_GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE, PH_STREAM, PH_WAIT, PH_WINDOW
    } phase_t;

    function automatic logic [4:0] core_opcode(input logic [3:0] cmd);
        case (cmd)
            CMD_LDPRM: return OPC_LDPRM;
            CMD_LDW:   return OPC_LDW;
            CMD_LDDAT: return OPC_LDDAT;
            CMD_NTT:   return OPC_NTT;
            CMD_PWM:   return OPC_PWM;
            CMD_INTT:  return OPC_INTT;
            CMD_XFER:  return OPC_XFER;
            CMD_READ:  return OPC_READ;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic phase_t cmd_phase(input logic [3:0] cmd);
        case (cmd)
            CMD_LDPRM, CMD_LDW, CMD_LDDAT: return PH_STREAM;
            CMD_NTT, CMD_PWM, CMD_INTT:    return PH_WAIT;
            CMD_XFER, CMD_READ:            return PH_WINDOW;
            default:                       return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ntt_seq_cnt.sv
// Clearable up-counter that saturates at a programmable limit and flags when
// the limit has been reached.
module ntt_seq_cnt #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         term
);

    assign term = (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !term)
            count <= count + W'(1);
    end

endmodule

// File: rtl/ntt_op_sequencer.sv
// Host-command sequencer for NTT1024: issues one-cycle opcodes, streams host
// words to the core, times valid windows and waits for done with a timeout.
module ntt_op_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int MAX_DEPTH  = 10,
    parameter int TMO_W      = 20,
    parameter int TMO_CYC    = 200000,
    parameter int XFER_EXTRA = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_arg,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        core_done,
    output logic [4:0]  OP_CODE,
    output logic        din_valid,
    output logic [31:0] din0,
    output logic [11:0] ring_size,
    output logic [3:0]  ring_depth,
    output logic [3:0]  limit,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0]       DEPTH_MAX = 4'(MAX_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(TMO_CYC);

    function automatic logic [CNT_W-1:0] cmd_len(input logic [3:0] cmd,
                                                 input logic [11:0] rs);
        logic [CNT_W-1:0] r;
        r = {1'b0, rs};
        case (cmd)
            CMD_LDPRM:          return 13'd3;
            CMD_LDW:            return r - 13'd1;
            CMD_LDDAT:          return {rs, 1'b0};
            CMD_XFER, CMD_READ: return r + 13'(XFER_EXTRA);
            default:            return '0;
        endcase
    endfunction

    state_t           state;
    phase_t           phase;
    logic [CNT_W-1:0] n_len;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_count;
    logic [TMO_W-1:0] t_count;
    logic             w_term;
    logic             t_term;
    logic             done_q;
    logic             blind;
    logic             accept;
    logic             w_inc;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign s_ready   = (state == S_STREAM) && !w_term;
    assign limit     = ring_depth;

    // A window of N cycles ends when the counter shows N-1 (the Nth cycle).
    assign w_limit = (state == S_WINDOW) ? n_len - 13'd1 : n_len;
    assign w_inc   = (state == S_STREAM && s_valid && s_ready) ||
                     (state == S_WINDOW && !w_term);

    ntt_seq_cnt #(.W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (state == S_ISSUE),
        .inc   (w_inc),
        .limit (w_limit),
        .count (w_count),
        .term  (w_term)
    );

    ntt_seq_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (state == S_ISSUE),
        .inc   (state == S_WAIT),
        .limit (TMO_LIM),
        .count (t_count),
        .term  (t_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= PH_NONE;
            n_len      <= '0;
            OP_CODE    <= '0;
            din_valid  <= 1'b0;
            din0       <= '0;
            ring_depth <= DEPTH_MAX;
            ring_size  <= 12'(1 << MAX_DEPTH);
            err        <= 1'b0;
            done_q     <= 1'b0;
            blind      <= 1'b0;
        end else begin
            err     <= 1'b0;
            OP_CODE <= '0;
            done_q  <= core_done;
            case (state)
                S_IDLE: begin
                    din_valid <= 1'b0;
                    if (accept) begin
                        if (cmd_op == CMD_CFG) begin
                            if (cmd_arg > DEPTH_MAX) begin
                                err <= 1'b1;
                            end else begin
                                ring_depth <= cmd_arg;
                                ring_size  <= 12'd1 << cmd_arg;
                            end
                        end else if (cmd_phase(cmd_op) == PH_NONE) begin
                            err <= 1'b1;
                        end else begin
                            phase     <= cmd_phase(cmd_op);
                            n_len     <= cmd_len(cmd_op, ring_size);
                            OP_CODE   <= core_opcode(cmd_op);
                            din_valid <= (cmd_phase(cmd_op) == PH_WINDOW);
                            din0      <= '0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    din_valid <= (phase == PH_WINDOW);
                    din0      <= '0;
                    blind     <= 1'b1;
                    case (phase)
                        PH_STREAM: state <= S_STREAM;
                        PH_WAIT:   state <= S_WAIT;
                        PH_WINDOW: state <= S_WINDOW;
                        default:   state <= S_GAP;
                    endcase
                end
                S_STREAM: begin
                    if (w_term) begin
                        din_valid <= 1'b0;
                        state     <= S_GAP;
                    end else if (s_valid) begin
                        din_valid <= 1'b1;
                        din0      <= s_data;
                    end else begin
                        din_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // done_q blocks a level that was already high from counting as an edge
                    din_valid <= 1'b0;
                    blind     <= 1'b0;
                    if (t_term) begin
                        err   <= 1'b1;
                        state <= S_GAP;
                    end else if (!blind && core_done && !done_q) begin
                        state <= S_GAP;
                    end
                end
                S_WINDOW: begin
                    din_valid <= !w_term;
                    if (w_term)
                        state <= S_GAP;
                end
                S_GAP: begin
                    din_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    din_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
